// File: rtl/boot_load_ctrl.sv
// UART boot loader: decodes single-byte commands, streams a counted block of
// little-endian 32-bit words into instruction RAM, and releases/holds the CPU.
module boot_load_ctrl #(
  parameter int AW  = 12,
  parameter int TMO = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_start,
  output logic          cpu_run,
  output logic          busy,
  output logic          err,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WR     = 3'd4
  } state_t;

  localparam int TW = ($clog2(TMO) > 0) ? $clog2(TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  localparam logic [32:0]   MAX_N    = 33'd1 << AW;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   sh_q, sh_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          start_q, start_d;
  logic          run_q, run_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic [15:0]   n_cnt;
  logic [31:0]   word_nxt;
  logic          tmo_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    sh_d     = sh_q;
    bidx_d   = bidx_q;
    tmr_d    = tmr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    start_d  = 1'b0;
    run_d    = run_q;
    err_d    = err_q;
    n_cnt    = {rx_data, cnt_q[7:0]};
    word_nxt = {rx_data, sh_q[31:8]};
    tmo_hit  = (tmr_q == TMO_LAST);

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (rx_valid) begin
          case (rx_data)
            8'h4C: begin
              if (run_q) err_d = 1'b1;
              else       state_d = S_CNT_LO;
            end
            8'h47: begin
              start_d = 1'b1;
              run_d   = 1'b1;
            end
            8'h53:   run_d = 1'b0;
            8'h43:   err_d = 1'b0;
            default: err_d = 1'b1;
          endcase
        end
      end
      S_CNT_LO: begin
        if (rx_valid) begin
          cnt_d[7:0] = rx_data;
          state_d    = S_CNT_HI;
          tmr_d      = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CNT_HI: begin
        if (rx_valid) begin
          cnt_d = n_cnt;
          tmr_d = '0;
          if (n_cnt == 16'd0) begin
            state_d = S_IDLE;
          end else if ({17'd0, n_cnt} > MAX_N) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
            addr_d  = '0;
            bidx_d  = 2'd0;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          sh_d  = word_nxt;
          tmr_d = '0;
          if (bidx_q == 2'd3) begin
            // Write strobe is registered so it appears in the single WR cycle.
            state_d = S_WR;
            bidx_d  = 2'd0;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = word_nxt;
          end else begin
            bidx_d = bidx_q + 2'd1;
          end
        end else if (tmo_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          tmr_d   = '0;
          bidx_d  = 2'd0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WR: begin
        if (rx_valid) err_d = 1'b1;
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - 16'd1;
        tmr_d  = '0;
        if (cnt_q == 16'd1) state_d = S_IDLE;
        else                state_d = S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      bidx_q  <= '0;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      bidx_q  <= bidx_d;
      tmr_q   <= tmr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      run_q   <= run_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_start  = start_q;
  assign cpu_run    = run_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Bench for boot_load_ctrl: directed byte streams, RAM writes checked against
// an expected queue by an independent monitor, levels checked by the driver.
module tb_boot_load_ctrl;
  localparam int AW  = 12;
  localparam int TMO = 16;
  localparam int W   = AW + 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_start;
  logic          cpu_run;
  logic          busy;
  logic          err;
  logic [2:0]    dbg_state;

  boot_load_ctrl #(.AW(AW), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_start  (cpu_start),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int start_seen  = 0;
  int exp_starts  = 0;
  logic prev_start = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   bq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: all are entered at a falling edge
  task automatic send_nogap(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nogap(b);
    @(negedge clk);
  endtask

  task automatic send_q();
    foreach (bq[i]) send_byte(bq[i]);
  endtask

  task automatic send_g();
    exp_starts++;
    send_byte(8'h47);
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] want;
    if (imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", imem_waddr, imem_wdata);
      end else begin
        want = exp_q.pop_front();
        if ({imem_waddr, imem_wdata} !== want) begin
          errors++;
          $display("FAIL imem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   imem_waddr, imem_wdata, want[W-1:32], want[31:0]);
        end
      end
    end
    if (cpu_start === 1'b1) begin
      start_seen++;
      checks++;
      if (busy !== 1'b0 || prev_start) begin
        errors++;
        $display("FAIL cpu_start_pulse: busy=%0b prev_start=%0b expected busy=0 prev_start=0", busy, prev_start);
      end
    end
    prev_start = cpu_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    // a 'G' during reset must be ignored
    rx_data  = 8'h47;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_waddr", {20'd0, imem_waddr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
    check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_priority_run", {31'd0, cpu_run}, 32'd0);

    // two-word load
    push_word(12'd0, 32'h0000_0013);
    push_word(12'd1, 32'h0010_0093);
    send_byte(8'h4C);
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_state_cnt_lo", {29'd0, dbg_state}, 32'd1);
    bq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_q();
    check("load_done_busy", {31'd0, busy}, 32'd0);
    check("load_done_err", {31'd0, err}, 32'd0);
    check("load_drained", exp_q.size(), 32'd0);

    // go, restart, stop
    send_g();
    check("go_run", {31'd0, cpu_run}, 32'd1);
    check("go_starts", start_seen, exp_starts);
    send_g();
    check("restart_run", {31'd0, cpu_run}, 32'd1);
    check("restart_starts", start_seen, exp_starts);

    // 'L' while running
    send_byte(8'h4C);
    check("l_running_err", {31'd0, err}, 32'd1);
    check("l_running_state", {29'd0, dbg_state}, 32'd0);
    check("l_running_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h53);
    check("stop_run", {31'd0, cpu_run}, 32'd0);
    send_byte(8'h43);
    check("clear_err", {31'd0, err}, 32'd0);

    // N = 0 and N = 4097
    bq = '{8'h4C, 8'h00, 8'h00};
    send_q();
    check("n0_busy", {31'd0, busy}, 32'd0);
    check("n0_err", {31'd0, err}, 32'd0);
    bq = '{8'h4C, 8'h01, 8'h10};
    send_q();
    check("n4097_err", {31'd0, err}, 32'd1);
    check("n4097_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h43);
    check("n4097_clear", {31'd0, err}, 32'd0);

    // unknown command
    send_byte(8'h55);
    check("bad_cmd_err", {31'd0, err}, 32'd1);
    send_byte(8'h43);

    // inter-byte timeout mid-word
    bq = '{8'h4C, 8'h01, 8'h00, 8'hAA};
    send_q();
    repeat (14) @(negedge clk);
    check("tmo_15_busy", {31'd0, busy}, 32'd1);
    check("tmo_15_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("tmo_16_busy", {31'd0, busy}, 32'd0);
    check("tmo_16_err", {31'd0, err}, 32'd1);
    send_byte(8'h43);
    push_word(12'd0, 32'hDEAD_BEEF);
    bq = '{8'h4C, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_q();
    check("after_tmo_err", {31'd0, err}, 32'd0);
    check("after_tmo_drained", exp_q.size(), 32'd0);

    // byte arriving during the write cycle is dropped and flagged
    push_word(12'd0, 32'h4433_2211);
    push_word(12'd1, 32'h8877_6655);
    bq = '{8'h4C, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_q();
    send_nogap(8'h44);
    send_byte(8'hFF);
    check("wr_byte_err", {31'd0, err}, 32'd1);
    bq = '{8'h55, 8'h66, 8'h77, 8'h88};
    send_q();
    check("wr_byte_drained", exp_q.size(), 32'd0);
    check("wr_byte_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h43);

    // reset in the middle of a word
    send_byte(8'h00);
    check("pre_rst_err", {31'd0, err}, 32'd1);
    bq = '{8'h4C, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_q();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_waddr", {20'd0, imem_waddr}, 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    rst = 1'b0;
    bq = '{8'hCC, 8'hDD};
    send_q();
    repeat (20) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("final_drained", exp_q.size(), 32'd0);
    check("final_starts", start_seen, exp_starts);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
